// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command issue stage.
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_RSUB = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_NOP  = 3'd7;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [2:0]        op;
        logic              use_acc;
    } alu_cmd_t;

    localparam int CMD_W = $bits(alu_cmd_t);

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; extra pointer MSB separates full from empty.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [CMD_W-1:0] din,
    output logic [CMD_W-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage ahead of the combinational ALU: command queue, operand drive,
// accumulator forwarding and a single registered result slot.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [2:0]        in_op,
    input  logic              in_use_acc,
    input  logic              acc_clr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_oper,
    input  logic [DATA_W-1:0] alu_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [2:0]        out_op,
    output logic              out_zero,
    output logic [15:0]       issue_cnt
);
    alu_cmd_t          in_cmd;
    alu_cmd_t          head_cmd;
    logic [CMD_W-1:0]  head_bits;
    logic              full;
    logic              empty;
    logic              issue;
    logic [DATA_W-1:0] acc;

    assign in_cmd   = '{a: in_a, b: in_b, op: in_op, use_acc: in_use_acc};
    assign head_cmd = alu_cmd_t'(head_bits);
    assign in_ready = !full;
    assign issue    = !empty && (!out_valid || out_ready);
    assign out_zero = (out_result == '0);

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid && in_ready),
        .pop   (issue),
        .din   (in_cmd),
        .head  (head_bits),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_oper = OP_NOP;
        if (!empty) begin
            alu_a    = head_cmd.use_acc ? acc : head_cmd.a;
            alu_b    = head_cmd.b;
            alu_oper = head_cmd.op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_op     <= '0;
            issue_cnt  <= '0;
        end else if (issue) begin
            out_valid  <= 1'b1;
            out_result <= alu_sum;
            out_op     <= head_cmd.op;
            issue_cnt  <= issue_cnt + 16'd1;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Clear wins over an issue update; the issuing command already saw the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       acc <= '0;
        else if (acc_clr) acc <= '0;
        else if (issue)   acc <= alu_sum;
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural 8-bit ALU on the return path.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        clk, rst_n;
    logic        in_valid, in_ready, in_use_acc, acc_clr;
    logic [7:0]  in_a, in_b, alu_a, alu_b, alu_sum, out_result;
    logic [2:0]  in_op, alu_oper, out_op;
    logic        out_valid, out_ready, out_zero;
    logic [15:0] issue_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [10:0] exp_q[$];
    logic [10:0] mon_e;

    alu_issue_ctrl #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_use_acc(in_use_acc),
        .acc_clr(acc_clr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper), .alu_sum(alu_sum),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_op(out_op), .out_zero(out_zero),
        .issue_cnt(issue_cnt)
    );

    always_comb begin
        alu_sum = 8'h00;
        case (alu_oper)
            OP_ADD:  alu_sum = alu_a + alu_b;
            OP_SUB:  alu_sum = alu_a - alu_b;
            OP_RSUB: alu_sum = alu_b - alu_a;
            OP_OR:   alu_sum = alu_a | alu_b;
            OP_AND:  alu_sum = alu_a & alu_b;
            OP_XOR:  alu_sum = alu_a ^ alu_b;
            OP_XNOR: alu_sum = ~(alu_a ^ alu_b);
            default: alu_sum = 8'h00;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a result is consumed at the edge following a negedge with valid && ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got 0x%0h expected none", out_result);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", 32'(out_result), 32'(mon_e[10:3]));
                check("result_op", 32'(out_op), 32'(mon_e[2:0]));
                check("result_zero", 32'(out_zero), 32'(mon_e[10:3] == 8'h00));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                            input logic ua, input logic [7:0] exp_res);
        int guard = 0;
        in_a = a; in_b = b; in_op = op; in_use_acc = ua; in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: in_ready 0 expected 1");
        end else begin
            exp_q.push_back({exp_res, op});
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_result"}, 32'(out_result), 32'd0);
        check({tag, "_out_op"}, 32'(out_op), 32'd0);
        check({tag, "_out_zero"}, 32'(out_zero), 32'd1);
        check({tag, "_issue_cnt"}, 32'(issue_cnt), 32'd0);
        check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        check({tag, "_alu_oper"}, 32'(alu_oper), 32'd7);
        check({tag, "_acc"}, 32'(dut.acc), 32'd0);
    endtask

    // Mixed-op table: {a, b, op, use_acc, expected}
    logic [27:0] tbl [4];
    logic [26:0] bp  [6];

    initial begin
        tbl[0] = {8'hFF, 8'h55, OP_OR,   1'b1, 8'h55};
        tbl[1] = {8'h12, 8'h34, OP_NOP,  1'b0, 8'h00};
        tbl[2] = {8'h05, 8'h0A, OP_SUB,  1'b0, 8'hFB};
        tbl[3] = {8'hA5, 8'h0F, OP_XNOR, 1'b0, 8'h55};
        bp[0]  = {8'h01, 8'h02, OP_ADD,  8'h03};
        bp[1]  = {8'h10, 8'h01, OP_SUB,  8'h0F};
        bp[2]  = {8'h03, 8'h01, OP_RSUB, 8'hFE};
        bp[3]  = {8'hF0, 8'h0F, OP_OR,   8'hFF};
        bp[4]  = {8'h3C, 8'h0F, OP_AND,  8'h0C};
        bp[5]  = {8'hAA, 8'hFF, OP_XOR,  8'h55};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        in_use_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        #3;
        check_reset_state("reset");
        step(); step();
        rst_n = 1'b1;
        step();

        // ADD with overflow into bit 7
        push_cmd(8'h7F, 8'h01, OP_ADD, 1'b0, 8'h80);
        check("add_alu_a", 32'(alu_a), 32'h7F);
        check("add_alu_b", 32'(alu_b), 32'h01);
        check("add_alu_oper", 32'(alu_oper), 32'(OP_ADD));
        step();
        check("add_out_valid", 32'(out_valid), 32'd1);
        check("add_out_result", 32'(out_result), 32'h80);
        check("add_out_zero", 32'(out_zero), 32'd0);
        check("add_issue_cnt", 32'(issue_cnt), 32'd1);

        // RSUB, then XOR to zero
        push_cmd(8'h05, 8'h0A, OP_RSUB, 1'b0, 8'h05);
        push_cmd(8'h33, 8'h33, OP_XOR, 1'b0, 8'h00);
        step();
        check("xor_out_zero", 32'(out_zero), 32'd1);
        check("xor_issue_cnt", 32'(issue_cnt), 32'd3);

        // Chain through the accumulator
        push_cmd(8'h10, 8'h20, OP_ADD, 1'b0, 8'h30);
        push_cmd(8'hFF, 8'h0F, OP_AND, 1'b1, 8'h00);
        check("chain_fwd_alu_a", 32'(alu_a), 32'h30);
        step();
        check("chain_acc", 32'(dut.acc), 32'h00);
        check("chain_issue_cnt", 32'(issue_cnt), 32'd5);

        // acc_clr on the issuing edge: command uses old acc, acc ends cleared
        push_cmd(8'h10, 8'h20, OP_ADD, 1'b0, 8'h30);
        push_cmd(8'hFF, 8'h3C, OP_AND, 1'b1, 8'h30);
        check("clr_fwd_alu_a", 32'(alu_a), 32'h30);
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        check("clr_out_result", 32'(out_result), 32'h30);
        check("clr_acc", 32'(dut.acc), 32'h00);

        for (int i = 0; i < 4; i++)
            push_cmd(tbl[i][27:20], tbl[i][19:12], tbl[i][11:9], tbl[i][8], tbl[i][7:0]);
        step();
        check("table_issue_cnt", 32'(issue_cnt), 32'd11);
        check("nop_last_op", 32'(out_op), 32'(OP_XNOR));
        step(); step();

        // Backpressure: one issues, four fill the FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_cmd(bp[i][26:19], bp[i][18:11], bp[i][10:8], 1'b0, bp[i][7:0]);
        check("full_in_ready", 32'(in_ready), 32'd0);
        step(); step(); step();
        check("hold_out_valid", 32'(out_valid), 32'd1);
        check("hold_out_result", 32'(out_result), 32'h03);
        check("hold_out_op", 32'(out_op), 32'(OP_ADD));
        check("hold_in_ready", 32'(in_ready), 32'd0);
        check("hold_issue_cnt", 32'(issue_cnt), 32'd12);
        out_ready = 1'b1;
        push_cmd(bp[5][26:19], bp[5][18:11], bp[5][10:8], 1'b0, bp[5][7:0]);
        for (int i = 0; i < 8; i++) step();
        check("drain_issue_cnt", 32'(issue_cnt), 32'd17);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_queue_left", 32'(exp_q.size()), 32'd0);

        // Reset with three commands queued and a result pending
        out_ready = 1'b0;
        push_cmd(8'h01, 8'h01, OP_ADD, 1'b0, 8'h02);
        push_cmd(8'h02, 8'h02, OP_ADD, 1'b0, 8'h04);
        push_cmd(8'h03, 8'h03, OP_ADD, 1'b0, 8'h06);
        push_cmd(8'h04, 8'h04, OP_ADD, 1'b0, 8'h08);
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_state("midrst");
        step(); step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_issue_cnt", 32'(issue_cnt), 32'd0);

        // Counter wrap: 65535 streamed issues, then one more
        for (int i = 0; i < 65535; i++)
            push_cmd(8'(i), 8'h01, OP_ADD, 1'b0, 8'(i + 1));
        step();
        check("cnt_ffff", 32'(issue_cnt), 32'hFFFF);
        push_cmd(8'h00, 8'hFF, OP_ADD, 1'b0, 8'hFF);
        step();
        check("cnt_wrap", 32'(issue_cnt), 32'h0000);
        step(); step();
        check("final_queue_left", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
